// File: rtl/if_queue_pkg.sv
// Shared fetch-path constants and the stored entry layout for the
// instruction queue between the PC/ROM stage and decode.
package if_queue_pkg;

  localparam int          InstAddrBus  = 32;
  localparam int          InstBus      = 32;
  localparam logic [31:0] NopInst      = 32'h0000_0000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        RstEnable    = 1'b1;
  localparam int          IfQueueDepth = 4;
  localparam int          IfQueueAw    = 2;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } if_entry_t;

endpackage

// File: rtl/if_queue_mem.sv
// DEPTH x {pc, inst} register file: one synchronous write port,
// one asynchronous read port feeding the queue head.
module if_queue_mem
  import if_queue_pkg::*;
#(
  parameter int DEPTH = IfQueueDepth,
  parameter int AW    = IfQueueAw
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  if_entry_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output if_entry_t     rdata_o
);

  if_entry_t mem_q [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by count in the parent,
  // and unoccupied slots are masked at the outputs, so stale data is harmless.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_queue.sv
// Instruction fetch queue: decouples ROM delivery from decode.
// Define IF_QUEUE_SKID_EN to raise full_o one entry early (skid slot).
module if_queue
  import if_queue_pkg::*;
#(
  parameter int DEPTH = IfQueueDepth,
  parameter int AW    = IfQueueAw
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic                   inst_valid_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic [InstBus-1:0]     inst_i,
  input  logic                   flush_i,
  input  logic                   id_ready_i,
  output logic                   full_o,
  output logic                   id_valid_o,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic [AW:0]            count_o,
  output logic                   ovf_o
);

  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          offer, do_enq, do_deq;
  if_entry_t     wdata, head;

  assign offer  = ce_i & inst_valid_i & ~flush_i;
  // Room is judged on the registered count alone: a same-cycle dequeue
  // never makes space for the incoming word.
  assign do_enq = offer & (count_q < DepthC);
  assign do_deq = id_valid_o & id_ready_i & ~flush_i;
  assign wdata  = '{pc: pc_i, inst: inst_i};

  // NOTE: combinational next-state assigns every output a default first so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (offer & (count_q == DepthC));
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) wptr_d = wptr_q + AW'(1);
      if (do_deq) rptr_d = rptr_q + AW'(1);
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  if_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (do_enq),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  assign id_valid_o = (count_q != '0);
  assign id_pc_o    = id_valid_o ? head.pc   : ZeroWord;
  assign id_inst_o  = id_valid_o ? head.inst : NopInst;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;

`ifdef IF_QUEUE_SKID_EN
  localparam logic [AW:0] SkidC = (AW+1)'(DEPTH-1);
  assign full_o = (count_q >= SkidC);
`else
  assign full_o = (count_q == DepthC);
`endif

endmodule
